// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and widths for the convolution sequencer
package conv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_e;

   localparam int PHASES = 3;
   localparam int SUM_W  = 17;
   localparam int ACC_W  = 19;
   localparam int PIX_W  = 8;

endpackage

// File: rtl/conv_pos_counter.sv
// rtl/conv_pos_counter.sv - output-map column/row tracker with end-of-frame flag
module conv_pos_counter #(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28,
   parameter int COL_W = 5,
   parameter int ROW_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             adv_i,
   output logic [COL_W-1:0] col_o,
   output logic [ROW_W-1:0] row_o,
   output logic             last_o
);

   localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 3);
   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 3);

   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;

   // raster advance: column wraps into the next row, last row wraps to the top
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (adv_i) begin
         if (col_q == COL_MAX) begin
            col_d = '0;
            row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   // position registers, cleared by reset so a new frame starts at (0,0)
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign col_o  = col_q;
   assign row_o  = row_q;
   assign last_o = (col_q == COL_MAX) && (row_q == ROW_MAX);

endmodule

// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - 3-phase conv datapath controller; CONV_SAT_EN selects saturating res_pix
module conv_sequencer
   import conv_pkg::*;
#(
   parameter int IMG_W    = 28,
   parameter int IMG_H    = 28,
   parameter int PIPE_LAT = 2,
   parameter int SHIFT    = 0,
   localparam int COL_W   = (IMG_W > 3) ? $clog2(IMG_W - 2) : 1,
   localparam int ROW_W   = (IMG_H > 3) ? $clog2(IMG_H - 2) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             win_load,
   output logic [1:0]       select,
   input  logic [SUM_W-1:0] sum_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] res_acc,
   output logic [PIX_W-1:0] res_pix,
   output logic [COL_W-1:0] out_col,
   output logic [ROW_W-1:0] out_row,
   output logic             frame_done
);

   state_e              state_q, state_d;
   logic [1:0]          phase_q, phase_d;
   logic [PIPE_LAT-1:0] tag_q, tag_d;
   logic [1:0]          cap_q, cap_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic                capture;
   logic                pos_last;

   // a tag leaving the delay line marks the cycle its phase's sum is on sum_in
   assign capture = tag_q[PIPE_LAT-1];

   // phase FSM: next state and handshake/select outputs
   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      in_ready  = 1'b0;
      win_load  = 1'b0;
      select    = 2'd0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = !rst;
            if (in_valid && !rst) begin
               win_load = 1'b1;
               phase_d  = 2'd0;
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            select = phase_q;
            if (phase_q == 2'(PHASES - 1)) begin
               phase_d = 2'd0;
               state_d = DRAIN;
            end else begin
               phase_d = phase_q + 2'd1;
            end
         end
         DRAIN: begin
            if (capture && (cap_q == 2'(PHASES - 1))) begin
               state_d = OUT;
            end
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // tag delay line and accumulator; accept clears, each emerging tag adds one partial sum
   always_comb begin
      tag_d    = tag_q;
      tag_d[0] = (state_q == ISSUE);
      for (int i = 1; i < PIPE_LAT; i++) begin
         tag_d[i] = tag_q[i-1];
      end
      acc_d = acc_q;
      cap_d = cap_q;
      if (win_load) begin
         acc_d = '0;
         cap_d = 2'd0;
      end else if (capture) begin
         acc_d = acc_q + {{(ACC_W - SUM_W){1'b0}}, sum_in};
         cap_d = cap_q + 2'd1;
      end
   end

   // state, phase, tag and accumulator registers; reset drops any in-flight window
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         phase_q <= 2'd0;
         tag_q   <= '0;
         cap_q   <= 2'd0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         tag_q   <= tag_d;
         cap_q   <= cap_d;
         acc_q   <= acc_d;
      end
   end

   conv_pos_counter #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .COL_W (COL_W),
      .ROW_W (ROW_W)
   ) u_pos (
      .clk    (clk),
      .rst    (rst),
      .adv_i  (out_valid && out_ready),
      .col_o  (out_col),
      .row_o  (out_row),
      .last_o (pos_last)
   );

   assign frame_done = out_valid && pos_last;
   assign res_acc    = acc_q;

`ifdef CONV_SAT_EN
   logic [ACC_W-1:0] acc_shr;
   assign acc_shr = acc_q >> SHIFT;
   assign res_pix = (|acc_shr[ACC_W-1:PIX_W]) ? {PIX_W{1'b1}} : acc_shr[PIX_W-1:0];
`else
   assign res_pix = acc_q[SHIFT+PIX_W-1:SHIFT];
`endif

endmodule

// File: doc/conv_sequencer.md
# conv_sequencer

Controller for the time-multiplexed 3x3 convolution datapath. It accepts one window at a time from the upstream window source and steps the datapath's 2-bit `select` through phases 0, 1 and 2. It then accumulates the three registered partial sums, taking the datapath pipeline delay into account, and presents one result per window through a valid/ready handshake. It also tracks the output-map position of each result and flags end of frame.

## Interface
Parameters:
- `IMG_W`, default 28: input image width in pixels; must be ≥ 3.
- `IMG_H`, default 28: input image height in pixels; must be ≥ 3.
- `PIPE_LAT`, default 2: cycles from `select` change to the matching `sum_in`; must be ≥ 1.
- `SHIFT`, default 0: right shift applied to the accumulator before forming `res_pix`.

Ports (clock and reset first):
- `clk`, input, 1: rising-edge clock; the only clock.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: upstream has a window ready.
- `in_ready`, output, 1: sequencer can accept a window; high only in IDLE.
- `win_load`, output, 1: one-cycle pulse on accept; upstream latches the window into the datapath image/kernel inputs on this edge and holds it until the next `win_load`.
- `select`, output, 2: phase select to the datapath.
- `sum_in`, input, 17: datapath registered sum.
- `out_valid`, output, 1: result available.
- `out_ready`, input, 1: downstream accepts the result.
- `res_acc`, output, 19: full accumulated sum.
- `res_pix`, output, 8: scaled pixel (see Configuration).
- `out_col`, output, $clog2(IMG_W-2): column of the current result.
- `out_row`, output, $clog2(IMG_H-2): row of the current result.
- `frame_done`, output, 1: high with `out_valid` on the last window of the frame.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - ISSUE: 3 cycles; `select` = 0, 1, 2.
  - DRAIN: waits until the last capture.
  - OUT: `out_valid`=1.
- IDLE→ISSUE on `in_valid && in_ready`. In that same cycle, `win_load`=1 and the accumulator clears to 0.
- ISSUE→DRAIN after phase 2.
- DRAIN→OUT after the third capture.
- OUT→IDLE on `out_valid && out_ready`.
- Capture: a PIPE_LAT-deep shift register of phase-valid tags follows each ISSUE cycle. When a tag emerges, `acc <= acc + sum_in`, zero-extended from 17 to 19 bits.
  - The 19-bit width cannot overflow, since 3 × (2^17 − 1) < 2^19.
- `select` is held at 0 outside ISSUE.
- `res_acc` and `res_pix` are stable throughout OUT, including while `out_ready` is low.
- Position counters:
  - On each output handshake, `out_col` increments.
  - At IMG_W−3, `out_col` wraps to 0 and `out_row` increments.
  - At (IMG_W−3, IMG_H−3), both wrap to 0; this is the result on which `frame_done` is high.
- Backpressure: no new window is accepted while in OUT.
- `in_valid` in non-IDLE states is ignored; no buffering.
- Reset values: every output is 0, the state is IDLE, the counters are 0 and the accumulator is 0.
  - Exception: `in_ready` goes to 1 on the first cycle after `rst` deasserts.
- Reset mid-operation: an in-flight window is discarded, no `out_valid` is produced, and the position counters return to 0.

## Timing
- Accept cycle is C0, with `win_load`=1 in C0.
- ISSUE cycles are C1..C3, with `select` = 0/1/2.
- Captures occur at the end of C(1+PIPE_LAT) .. C(3+PIPE_LAT).
- `out_valid` first goes high in C(4+PIPE_LAT); with the default PIPE_LAT=2, this is C6.
- If `out_ready` is high in the first OUT cycle, `in_ready` is high in the next cycle.
  - Minimum period is PIPE_LAT+5 cycles per window.
- `frame_done` and the position outputs are registered and aligned with `out_valid`.

## Configuration
- Macro: `CONV_SAT_EN`.
- Defined: `res_pix = min(res_acc >> SHIFT, 255)`, i.e. saturating.
- Undefined: `res_pix = res_acc[SHIFT+7:SHIFT]`, i.e. truncating, with no clamp logic.
- `res_acc` is unaffected by the macro.

## Structure
- Package `conv_pkg` holds:
  - the state enum (IDLE, ISSUE, DRAIN, OUT);
  - `PHASES` = 3;
  - `SUM_W` = 17 and `ACC_W` = 19;
  - `PIX_W` = 8.
- Sub-module `conv_pos_counter`: column/row counters with wrap logic and `frame_done` generation, advanced by the output-handshake strobe.
- The phase FSM, tag shift register and accumulator live in the top module.

## Test plan
- **Single window:** `sum_in` model with PIPE_LAT=2 returns 100, 200, 300 for phases 0/1/2 → `select` sequence 0,1,2 in C1–C3; `out_valid` in C6; `res_acc`=600, `res_pix`=255 with `CONV_SAT_EN` or 88 without.
- **Max values:** `sum_in`=131071 for all phases → `res_acc`=393213, with no overflow.
- **Backpressure:** `out_ready` low for 5 cycles → result held constant and `in_ready` stays 0; accept occurs in the cycle after `out_ready` rises.
- **Frame wrap, IMG_W=IMG_H=5:** 9 windows → positions (0,0)…(2,2) in raster order; `frame_done` only on the 9th; the 10th result is at (0,0).
- **Reset mid-ISSUE:** `rst` asserted in C2 → next cycle all outputs are 0 and the state is IDLE; no `out_valid` follows; the next window starts counting at (0,0).
- **PIPE_LAT=1 instance:** `out_valid` in C5 with correct sum.
